// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - round/draw/timer sequencer driven by an external game step code
//
// Purpose: follows the game FSM step code and supplies the timing side of a round:
// random symbol draws, the play-phase countdown and the result-screen hold.
// Optional feature macro: SEQ_TIMEOUT_EN (play countdown and timeout pulse);
// when undefined, time_left and timeout are tied low.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   step[3:0]  in   game step: 0000 idle, 0001 draw, 0010 play, 0011 show, 0111 result, 1000 win
//   select     in   player confirm, freezes the play countdown while high
//   rand_ready out  one-cycle pulse, rand_val holds a fresh symbol
//   rand_val   out  latched random symbol, never zero
//   done       out  round count has reached MAX_ROUNDS
//   finish     out  one-cycle pulse, result hold expired
//   timeout    out  one-cycle pulse, play countdown expired
//   round      out  draws completed in the current game
//   time_left  out  remaining play ticks
module game_sequencer #(
    parameter int TICK_DIV    = 25000000,
    parameter int ROUND_TICKS = 10,
    parameter int MAX_ROUNDS  = 8,
    parameter int HOLD_TICKS  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] step,
    input  logic       select,
    output logic       rand_ready,
    output logic [3:0] rand_val,
    output logic       done,
    output logic       finish,
    output logic       timeout,
    output logic [3:0] round,
    output logic [3:0] time_left
);

    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [2:0] {S_IDLE, S_MIX, S_WAIT, S_PLAY, S_HOLD} state_t;

    state_t          state, state_n;
    logic [3:0]      step_q;
    logic [7:0]      lfsr;
    logic [1:0]      mix_cnt, mix_n;
    logic [3:0]      hold_cnt, hold_n;
    logic [PW-1:0]   presc, presc_n;
    logic [3:0]      round_n, rv_n;
    logic            rr_n, fin_n;
    logic            entry, tick;
    logic [3:0]      rand_sym;

`ifdef SEQ_TIMEOUT_EN
    logic [3:0]      tl_q, tl_n;
    logic            to_q, to_n;
    assign time_left = tl_q;
    assign timeout   = to_q;
`else
    logic            unused_select;
    assign unused_select = select;
    assign time_left     = 4'd0;
    assign timeout       = 1'b0;
`endif

    assign entry    = (step != step_q);
    assign tick     = (presc == PW'(TICK_DIV - 1));
    // A zero low nibble is remapped so the symbol is never blank.
    assign rand_sym = (lfsr[3:0] == 4'd0) ? 4'h1 : lfsr[3:0];
    assign done     = (round == 4'(MAX_ROUNDS));

    always_comb begin
        state_n = state;
        mix_n   = mix_cnt;
        hold_n  = hold_cnt;
        presc_n = presc;
        round_n = round;
        rv_n    = rand_val;
        rr_n    = 1'b0;
        fin_n   = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        tl_n    = tl_q;
        to_n    = 1'b0;
`endif
        if (step == 4'b0000) begin
            // Idle is level-driven: clears the game whatever was in flight.
            state_n = S_IDLE;
            round_n = 4'd0;
            mix_n   = 2'd0;
            hold_n  = 4'd0;
            presc_n = '0;
`ifdef SEQ_TIMEOUT_EN
            tl_n    = 4'd0;
`endif
        end else if (entry) begin
            // A new step aborts the running phase silently and starts its own.
            mix_n   = 2'd0;
            hold_n  = 4'd0;
            presc_n = '0;
            case (step)
                4'b0001: begin
                    if (round < 4'(MAX_ROUNDS)) begin
                        state_n = S_MIX;
                    end else begin
                        // Saturated game: answer at once, round stays put.
                        rr_n    = 1'b1;
                        rv_n    = rand_sym;
                        state_n = S_WAIT;
                    end
                end
                4'b0010: begin
                    state_n = S_PLAY;
`ifdef SEQ_TIMEOUT_EN
                    tl_n    = 4'(ROUND_TICKS);
`endif
                end
                4'b0111, 4'b1000: begin
                    state_n = S_HOLD;
                    hold_n  = 4'(HOLD_TICKS);
                end
                default: state_n = S_WAIT;
            endcase
        end else begin
            case (state)
                S_MIX: begin
                    // Let the LFSR churn a few clocks before sampling it.
                    if (mix_cnt == 2'd2) begin
                        rr_n    = 1'b1;
                        rv_n    = rand_sym;
                        round_n = round + 4'd1;
                        state_n = S_WAIT;
                    end else begin
                        mix_n = mix_cnt + 2'd1;
                    end
                end
                S_PLAY: begin
                    presc_n = tick ? '0 : presc + 1'b1;
`ifdef SEQ_TIMEOUT_EN
                    if (tick && !select && (tl_q != 4'd0)) begin
                        tl_n = tl_q - 4'd1;
                        to_n = (tl_q == 4'd1);
                    end
`endif
                end
                S_HOLD: begin
                    presc_n = tick ? '0 : presc + 1'b1;
                    if (tick) begin
                        if (hold_cnt == 4'd1) begin
                            fin_n   = 1'b1;
                            hold_n  = 4'd0;
                            state_n = S_WAIT;
                        end else begin
                            hold_n = hold_cnt - 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            step_q     <= 4'b0000;
            lfsr       <= 8'hA5;
            mix_cnt    <= 2'd0;
            hold_cnt   <= 4'd0;
            presc      <= '0;
            round      <= 4'd0;
            rand_val   <= 4'h1;
            rand_ready <= 1'b0;
            finish     <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            tl_q       <= 4'd0;
            to_q       <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            step_q     <= step;
            // x^8+x^6+x^5+x^4+1, free-running in every state.
            lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            mix_cnt    <= mix_n;
            hold_cnt   <= hold_n;
            presc      <= presc_n;
            round      <= round_n;
            rand_val   <= rv_n;
            rand_ready <= rr_n;
            finish     <= fin_n;
`ifdef SEQ_TIMEOUT_EN
            tl_q       <= tl_n;
            to_q       <= to_n;
`endif
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - self-checking bench for game_sequencer
module tb_game_sequencer;

    localparam int TICK_DIV    = 4;
    localparam int ROUND_TICKS = 3;
    localparam int MAX_ROUNDS  = 2;
    localparam int HOLD_TICKS  = 2;
`ifdef SEQ_TIMEOUT_EN
    localparam int TO_EN = 1;
`else
    localparam int TO_EN = 0;
`endif

    logic       clk, rst, select;
    logic [3:0] step;
    logic       rand_ready, done, finish, timeout;
    logic [3:0] rand_val, round, time_left;

    game_sequencer #(
        .TICK_DIV(TICK_DIV), .ROUND_TICKS(ROUND_TICKS),
        .MAX_ROUNDS(MAX_ROUNDS), .HOLD_TICKS(HOLD_TICKS)
    ) dut (
        .clk(clk), .rst(rst), .step(step), .select(select),
        .rand_ready(rand_ready), .rand_val(rand_val), .done(done),
        .finish(finish), .timeout(timeout), .round(round), .time_left(time_left)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: events are scheduled by clock count from the moment a
    // phase is entered, rather than tracked through a state machine.
    int         cyc, draw_due, hold_due, load_cyc;
    bit         play_on;
    logic [7:0] m_lfsr;
    logic [3:0] m_rv, m_round, m_tl, m_step_q, sym;
    logic       m_rr, m_fin, m_to;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_lfsr = 8'hA5; m_rv = 4'h1; m_round = 0; m_tl = 0;
                m_rr = 0; m_fin = 0; m_to = 0; m_step_q = 0;
                draw_due = -1; hold_due = -1; play_on = 0; cyc = 0; load_cyc = 0;
            end else begin
                cyc++;
                m_rr = 0; m_fin = 0; m_to = 0;
                sym = (m_lfsr[3:0] == 0) ? 4'h1 : m_lfsr[3:0];
                if (step == 4'd0) begin
                    m_round = 0; m_tl = 0;
                    draw_due = -1; hold_due = -1; play_on = 0;
                end else if (step != m_step_q) begin
                    draw_due = -1; hold_due = -1; play_on = 0;
                    if (step == 4'd1) begin
                        if (m_round < MAX_ROUNDS) draw_due = cyc + 3;
                        else begin m_rr = 1; m_rv = sym; end
                    end else if (step == 4'd2) begin
                        play_on = 1; load_cyc = cyc;
                        if (TO_EN != 0) m_tl = ROUND_TICKS;
                    end else if (step == 4'd7 || step == 4'd8) begin
                        hold_due = cyc + HOLD_TICKS * TICK_DIV;
                    end
                end else begin
                    if (draw_due == cyc) begin
                        m_rr = 1; m_rv = sym; m_round = m_round + 1; draw_due = -1;
                    end
                    if (play_on && ((cyc - load_cyc) % TICK_DIV == 0) && !select && m_tl > 0) begin
                        m_tl = m_tl - 1;
                        if (m_tl == 0) m_to = 1;
                    end
                    if (hold_due == cyc) begin
                        m_fin = 1; hold_due = -1;
                    end
                end
                m_step_q = step;
                m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
            end
        end
    end

    int n_rr, n_fin, n_to;

    task automatic cyc_step();
        @(negedge clk);
        chk("rand_ready", rand_ready, m_rr);
        chk("rand_val", rand_val, m_rv);
        chk("round", round, m_round);
        chk("done", done, (m_round == MAX_ROUNDS));
        chk("finish", finish, m_fin);
        chk("timeout", timeout, m_to);
        chk("time_left", time_left, m_tl);
        if (rand_ready) n_rr++;
        if (finish) n_fin++;
        if (timeout) n_to++;
    endtask

    typedef struct {
        logic [3:0] step;
        logic       sel;
        int         n;
        int         e_rr, e_round, e_done, e_fin, e_to, e_tl;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int lat, cnt, r, len;
        tbl[0]  = '{4'd0, 1'b0, 3,  0, 0, 0, 0, 0, 0};
        tbl[1]  = '{4'd1, 1'b0, 6,  1, 1, 0, 0, 0, 0};
        tbl[2]  = '{4'd2, 1'b0, 14, 0, 1, 0, 0, TO_EN, 0};
        tbl[3]  = '{4'd1, 1'b0, 6,  1, 2, 1, 0, 0, 0};
        tbl[4]  = '{4'd3, 1'b0, 2,  0, 2, 1, 0, 0, 0};
        tbl[5]  = '{4'd1, 1'b0, 3,  1, 2, 1, 0, 0, 0};
        tbl[6]  = '{4'd7, 1'b0, 10, 0, 2, 1, 1, 0, 0};
        tbl[7]  = '{4'd0, 1'b0, 2,  0, 0, 0, 0, 0, 0};
        tbl[8]  = '{4'd8, 1'b0, 5,  0, 0, 0, 0, 0, 0};
        tbl[9]  = '{4'd0, 1'b0, 4,  0, 0, 0, 0, 0, 0};
        tbl[10] = '{4'd2, 1'b1, 14, 0, 0, 0, 0, 0, 3 * TO_EN};
        tbl[11] = '{4'd2, 1'b0, 14, 0, 0, 0, 0, TO_EN, 0};
        tbl[12] = '{4'd1, 1'b0, 2,  0, 0, 0, 0, 0, 0};
        tbl[13] = '{4'd2, 1'b0, 5,  0, 0, 0, 0, 0, 2 * TO_EN};

        rst = 1'b1; step = 4'd0; select = 1'b0;
        #1;
        chk("reset_rand_val", rand_val, 4'h1);
        chk("reset_round", round, 0);
        chk("reset_pulses", {rand_ready, finish, timeout, done}, 0);
        repeat (2) cyc_step();
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            step = tbl[i].step; select = tbl[i].sel;
            n_rr = 0; n_fin = 0; n_to = 0;
            repeat (tbl[i].n) cyc_step();
            chk($sformatf("vec%0d_rr_count", i), n_rr, tbl[i].e_rr);
            chk($sformatf("vec%0d_round", i), round, tbl[i].e_round);
            chk($sformatf("vec%0d_done", i), done, tbl[i].e_done);
            chk($sformatf("vec%0d_fin_count", i), n_fin, tbl[i].e_fin);
            chk($sformatf("vec%0d_to_count", i), n_to, tbl[i].e_to);
            chk($sformatf("vec%0d_time_left", i), time_left, tbl[i].e_tl);
        end

        // Draw latency: pulse on the 4th edge after the step change.
        step = 4'd0; select = 1'b0;
        repeat (2) cyc_step();
        step = 4'd1; lat = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc_step();
            if (rand_ready && lat == 0) lat = i;
        end
        chk("draw_latency", lat, 4);
        chk("draw_rand_val_nonzero", (rand_val != 0), 1);

        // Result hold: single finish 8 clocks after the entry edge.
        step = 4'd7; lat = 0; cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc_step();
            if (finish) begin
                cnt++;
                if (lat == 0) lat = i;
            end
        end
        chk("finish_latency", lat, 9);
        chk("finish_count", cnt, 1);

        // Asynchronous reset in the middle of a draw.
        step = 4'd2;
        repeat (2) cyc_step();
        step = 4'd1;
        repeat (2) cyc_step();
        chk("pre_reset_round", round, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rand_val", rand_val, 4'h1);
        chk("async_round", round, 0);
        chk("async_time_left", time_left, 0);
        chk("async_pulses", {rand_ready, finish, timeout, done}, 0);
        step = 4'd0;
        repeat (2) cyc_step();
        rst = 1'b0;
        n_rr = 0;
        repeat (8) cyc_step();
        chk("no_rr_after_reset", n_rr, 0);

        // Randomized step sequences against the model.
        repeat (150) begin
            r = $urandom_range(0, 7);
            case (r)
                0: step = 4'd0;
                1: step = 4'd1;
                2, 3: step = 4'd2;
                4: step = 4'd3;
                5: step = 4'd7;
                6: step = 4'd8;
                default: step = 4'($urandom);
            endcase
            len = $urandom_range(1, 14);
            repeat (len) begin
                select = ($urandom_range(0, 3) == 0);
                cyc_step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 25000000: clk cycles per timer tick (1 s at 25 MHz); legal range >= 2.
REQ-002 Parameter ROUND_TICKS, default 10: play-phase countdown length in ticks; legal range 1..15.
REQ-003 Parameter MAX_ROUNDS, default 8: draws per game before done asserts; legal range 1..15.
REQ-004 Parameter HOLD_TICKS, default 5: result-screen hold length in ticks before finish; legal range 1..15.
REQ-005 clk  in  1  system clock; reset rst, asynchronous, active-high; clock clk.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 step  in  4  game FSM state: 0000 idle, 0001 draw, 0010 play, 0011 show, 0111 result, 1000 win.
REQ-008 select  in  1  player confirm, level-sampled each clk.
REQ-009 rand_ready  out  1  one-cycle pulse; rand_val is valid.
REQ-010 rand_val  out  4  latched random symbol, never 0.
REQ-011 done  out  1  level; round count has reached MAX_ROUNDS.
REQ-012 finish  out  1  one-cycle pulse; result hold expired.
REQ-013 timeout  out  1  one-cycle pulse; play countdown expired.
REQ-014 round  out  4  draws completed in the current game.
REQ-015 time_left  out  4  remaining play ticks.

Function
REQ-016 The LFSR shall be 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, free-running every clk in all states; on a zero lfsr[3:0], rand_val shall take 4'h1.
REQ-017 The tick prescaler shall count 0..TICK_DIV-1, pulse tick at TICK_DIV-1, and clear to 0 on every timer load.
REQ-018 Internal states: IDLE, MIX, WAIT, PLAY, HOLD; step_q shall register step, and entry = (step != step_q).
REQ-019 IDLE: on step==0000, the block shall enter IDLE and clear round, time_left and all timers from any state.
REQ-020 Draw: on entry to step 0001 with round < MAX_ROUNDS, MIX shall run 3 clks, then pulse rand_ready, latch rand_val, increment round, and enter WAIT.
REQ-021 If round == MAX_ROUNDS on draw entry, rand_ready shall pulse on the next clk without incrementing round (saturate).
REQ-022 done shall equal (round == MAX_ROUNDS), combinationally from the round register.
REQ-023 Play: on entry to step 0010, time_left shall load ROUND_TICKS, decrement on each tick, pulse timeout on the tick that takes it to 0, then hold 0.
REQ-024 select=1 in PLAY shall freeze time_left, with no timeout.
REQ-025 Result: on entry to step 0111 or 1000, the hold counter shall load HOLD_TICKS, decrement per tick, and pulse finish once at 0.
REQ-026 A step change mid-operation shall abort the current phase with no pulse and start the new phase's entry action in the same clk.
REQ-027 Step 0011 and undefined step codes shall place the block in WAIT, with no counting.

Reset
REQ-028 On rst: LFSR=8'hA5, rand_val=4'h1, round=0, time_left=0, rand_ready=finish=timeout=0, done=0, state IDLE, step_q=0000.
REQ-029 Release of rst shall take effect at the next clk edge, with no pulse output in the first clk.

Configuration
REQ-030 Macro SEQ_TIMEOUT_EN defined: play countdown and timeout per REQ-023/024.
REQ-031 Macro SEQ_TIMEOUT_EN undefined: timeout tied 0, time_left tied 0, and no play counter logic.

Verification (TICK_DIV=4, ROUND_TICKS=3, MAX_ROUNDS=2, HOLD_TICKS=2)
REQ-032 Reset then step 0000->0001 -> rand_ready pulses 4 clks after step changes, round=1, rand_val!=0, done=0.
REQ-033 Two draws (0001,0010,0001) -> round=2 and done=1; a third draw -> rand_ready pulses, round stays 2.
REQ-034 step=0010 held, select=0 -> time_left 3,2,1,0 every 4 clks and a single timeout pulse; with SEQ_TIMEOUT_EN undefined, time_left stays 0 and timeout never pulses.
REQ-035 step=0111 -> finish pulses exactly once 8 clks after entry; step->0000 at clk 5 -> no finish, round=0.
REQ-036 rst asserted during MIX -> outputs take the REQ-028 values immediately, asynchronously, and no rand_ready follows.
